// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding and a
// constant-evaluable log2 helper used to derive the address field widths.
// Field widths depend on module parameters, so each module derives them locally.
package instr_cache_pkg;

    // Miss-handling FSM: wait for a miss, fetch the block, write the line.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for a value of 1 so single-word blocks have no offset field.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage for the direct-mapped instruction cache: valid bits, tags, block data.
// Read port is combinational (0 cycles); write port commits a whole line on the clock edge.
// No backpressure: the owner serialises writes, one line per cycle at most.
module icache_line_array
    import instr_cache_pkg::*;
#(
    parameter int LINES       = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int INSTR_W     = 32,
    parameter int TAG_W       = 25,
    localparam int IDX_W      = clog2(LINES),
    localparam int OFF_SW     = (BLOCK_WORDS > 1) ? clog2(BLOCK_WORDS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    // combinational read port
    input  logic [IDX_W-1:0]               rd_idx,
    input  logic [OFF_SW-1:0]              rd_off,
    output logic                           rd_valid,
    output logic [TAG_W-1:0]               rd_tag,
    output logic [INSTR_W-1:0]             rd_word,
    // synchronous whole-line write port
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [TAG_W-1:0]               wr_tag,
    input  logic [INSTR_W*BLOCK_WORDS-1:0] wr_data
);

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [INSTR_W-1:0] data_q [LINES][BLOCK_WORDS];

    // Valid bits are the only state that must be cleared; reset wipes them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are don't-care while the line is invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                data_q[wr_idx][w] <= wr_data[w*INSTR_W +: INSTR_W];
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

    // A single-word block has no offset field; the offset input is then unused.
    if (BLOCK_WORDS == 1) begin : g_single_word
        logic unused_off;
        assign unused_off = ^rd_off;
        assign rd_word    = data_q[rd_idx][0];
    end else begin : g_multi_word
        assign rd_word = data_q[rd_idx][rd_off];
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between CPU fetch and block-wide instruction memory.
// Hit: 0 cycles, combinational. Miss: BUSYWAIT for 1 + memory busy cycles + 1 cycles.
// Stalls the CPU via BUSYWAIT; waits on MEM_BUSYWAIT with MEM_READ held for the whole fetch.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int INSTR_W     = 32,
    parameter int LINES       = 8,
    parameter int BLOCK_WORDS = 4,
    localparam int OFF_W      = clog2(BLOCK_WORDS),
    localparam int IDX_W      = clog2(LINES),
    localparam int BA_W       = PC_W - 2 - OFF_W,
    localparam int TAG_W      = BA_W - IDX_W,
    localparam int OFF_SW     = (OFF_W > 0) ? OFF_W : 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [PC_W-1:0]                PC,
    output logic [INSTR_W-1:0]             INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           MEM_READ,
    output logic [BA_W-1:0]                MEM_ADDRESS,
    input  logic [INSTR_W*BLOCK_WORDS-1:0] MEM_READDATA,
    input  logic                           MEM_BUSYWAIT
);

    // PC decomposition: {tag, index, offset, byte[1:0]}; block address is {tag, index}.
    logic [BA_W-1:0]   pc_blk;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [OFF_SW-1:0] pc_off;
    logic              unused_pc_byte;

    assign pc_blk         = PC[PC_W-1:2+OFF_W];
    assign pc_idx         = pc_blk[IDX_W-1:0];
    assign pc_tag         = pc_blk[BA_W-1:IDX_W];
    assign unused_pc_byte = ^PC[1:0];

    if (OFF_W == 0) begin : g_no_off
        assign pc_off = 1'b0;
    end else begin : g_off
        assign pc_off = PC[OFF_W+1:2];
    end

    // FSM state and registered memory-side outputs; miss_addr doubles as MEM_ADDRESS.
    state_t                     state;
    logic                       mem_read_q;
    logic [BA_W-1:0]            miss_addr;
    logic [INSTR_W*BLOCK_WORDS-1:0] fill_q;

    // Line array interface
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [INSTR_W-1:0] rd_word;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    logic               hit;

    icache_line_array #(
        .LINES       (LINES),
        .BLOCK_WORDS (BLOCK_WORDS),
        .INSTR_W     (INSTR_W),
        .TAG_W       (TAG_W)
    ) u_lines (
        .clk      (CLK),
        .rst      (RESET),
        .rd_idx   (pc_idx),
        .rd_off   (pc_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (fill_q)
    );

    assign hit = rd_valid && (rd_tag == pc_tag);

    // The line write always targets the latched miss address, never the live PC,
    // so a PC change during the fill cannot corrupt an unrelated line.
    assign wr_en  = (state == UPDATE);
    assign wr_idx = miss_addr[IDX_W-1:0];
    assign wr_tag = miss_addr[BA_W-1:IDX_W];

    // Miss-handling FSM: latch the block address, hold MEM_READ until memory answers,
    // then spend one cycle committing the line before re-evaluating the PC.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            mem_read_q <= 1'b0;
            miss_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_addr  <= pc_blk;
                        mem_read_q <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        mem_read_q <= 1'b0;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_read_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Capture the block in the cycle memory drops busy; a reset returns the FSM to IDLE,
    // so in-flight data is never captured or committed after it.
    always_ff @(posedge CLK) begin
        if (state == FETCH && !MEM_BUSYWAIT) begin
            fill_q <= MEM_READDATA;
        end
    end

    assign MEM_READ    = mem_read_q;
    assign MEM_ADDRESS = miss_addr;

    // Invalid lines read as zero; reset clears every valid bit, which also zeroes this output.
    assign INSTRUCTION = rd_valid ? rd_word : '0;

    // Stall on a miss in IDLE and throughout the fill; reset forces the stall low at once.
    assign BUSYWAIT = !RESET && ((state != IDLE) || !hit);

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: default geometry with a 5-cycle memory, plus
// LINES=2/BLOCK_WORDS=1 and LINES=16/BLOCK_WORDS=8 instances with a 1-cycle memory.
// Instance k is driven through pc_v[k] and observed through the *_v[k] arrays.
module tb_instr_cache;

    logic        CLK;
    logic        rst;
    logic [31:0] pc_v [3];

    logic [31:0] instr0, instr1, instr2;
    logic        busy0, busy1, busy2;
    logic        mread0, mread1, mread2;
    logic        mbusy0, mbusy1, mbusy2;
    logic [27:0] maddr0;
    logic [29:0] maddr1;
    logic [26:0] maddr2;
    logic [127:0] rdata0;
    logic [31:0]  rdata1;
    logic [255:0] rdata2;
    int cnt0, cnt1, cnt2;

    logic [31:0] instr_v [3];
    logic [31:0] maddr_v [3];
    logic        busy_v  [3];
    logic        mread_v [3];

    int checks;
    int failures;

    instr_cache u0 (
        .CLK(CLK), .RESET(rst), .PC(pc_v[0]), .INSTRUCTION(instr0), .BUSYWAIT(busy0),
        .MEM_READ(mread0), .MEM_ADDRESS(maddr0), .MEM_READDATA(rdata0), .MEM_BUSYWAIT(mbusy0)
    );

    instr_cache #(.LINES(2), .BLOCK_WORDS(1)) u1 (
        .CLK(CLK), .RESET(rst), .PC(pc_v[1]), .INSTRUCTION(instr1), .BUSYWAIT(busy1),
        .MEM_READ(mread1), .MEM_ADDRESS(maddr1), .MEM_READDATA(rdata1), .MEM_BUSYWAIT(mbusy1)
    );

    instr_cache #(.LINES(16), .BLOCK_WORDS(8)) u2 (
        .CLK(CLK), .RESET(rst), .PC(pc_v[2]), .INSTRUCTION(instr2), .BUSYWAIT(busy2),
        .MEM_READ(mread2), .MEM_ADDRESS(maddr2), .MEM_READDATA(rdata2), .MEM_BUSYWAIT(mbusy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference memory contents: instruction stored at word address wa.
    function automatic logic [31:0] word_of(input logic [31:0] wa);
        return wa * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    always_comb begin
        instr_v[0] = instr0;            instr_v[1] = instr1;            instr_v[2] = instr2;
        busy_v[0]  = busy0;             busy_v[1]  = busy1;             busy_v[2]  = busy2;
        mread_v[0] = mread0;            mread_v[1] = mread1;            mread_v[2] = mread2;
        maddr_v[0] = {4'b0, maddr0};    maddr_v[1] = {2'b0, maddr1};    maddr_v[2] = {5'b0, maddr2};
    end

    // Block data returned for the requested block address, word 0 in the LSBs.
    always_comb begin
        rdata0 = '0;
        for (int w = 0; w < 4; w++) rdata0[w*32 +: 32] = word_of({2'b0, maddr0, 2'b00} + 32'(w));
        rdata1 = word_of({2'b0, maddr1});
        rdata2 = '0;
        for (int w = 0; w < 8; w++) rdata2[w*32 +: 32] = word_of({2'b0, maddr2, 3'b000} + 32'(w));
    end

    // Memory busy model: data valid in the 5th (u0) or 1st (u1, u2) cycle of MEM_READ.
    assign mbusy0 = mread0 && (cnt0 != 4);
    assign mbusy1 = mread1 && (cnt1 != 0);
    assign mbusy2 = mread2 && (cnt2 != 0);

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt0 <= 0; cnt1 <= 0; cnt2 <= 0;
        end else begin
            cnt0 <= mread0 ? cnt0 + 1 : 0;
            cnt1 <= mread1 ? cnt1 + 1 : 0;
            cnt2 <= mread2 ? cnt2 + 1 : 0;
        end
    end

    // Present pc to instance k and follow the access until BUSYWAIT falls.
    task automatic fetch(input int k, input logic [31:0] pc, input logic exp_miss,
                         input logic [31:0] exp_addr, input int exp_stall, input string name);
        int          stall;
        logic        saw_rd;
        logic [31:0] bad_addr;
        logic        addr_ok;
        logic [31:0] exp_instr;
        stall    = 0;
        saw_rd   = 1'b0;
        addr_ok  = 1'b1;
        bad_addr = '0;
        pc_v[k]  = pc;
        #1;
        while (busy_v[k] === 1'b1 && stall < 100) begin
            if (mread_v[k] === 1'b1) begin
                saw_rd = 1'b1;
                if (maddr_v[k] !== exp_addr) begin
                    addr_ok  = 1'b0;
                    bad_addr = maddr_v[k];
                end
            end
            stall++;
            @(posedge CLK);
            #1;
        end
        exp_instr = word_of(pc >> 2);
        checks++;
        if (stall !== exp_stall) begin
            failures++;
            $display("FAIL %s[u%0d] pc=%h stall cycles: got %0d expected %0d", name, k, pc, stall, exp_stall);
        end
        checks++;
        if (saw_rd !== exp_miss) begin
            failures++;
            $display("FAIL %s[u%0d] pc=%h MEM_READ seen: got %0b expected %0b", name, k, pc, saw_rd, exp_miss);
        end
        if (exp_miss) begin
            checks++;
            if (!addr_ok) begin
                failures++;
                $display("FAIL %s[u%0d] pc=%h MEM_ADDRESS: got %h expected %h", name, k, pc, bad_addr, exp_addr);
            end
        end
        checks++;
        if (instr_v[k] !== exp_instr) begin
            failures++;
            $display("FAIL %s[u%0d] pc=%h INSTRUCTION: got %h expected %h", name, k, pc, instr_v[k], exp_instr);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_v[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset[u%0d] BUSYWAIT: got %b expected 0", k, busy_v[k]);
            end
            checks++;
            if (mread_v[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset[u%0d] MEM_READ: got %b expected 0", k, mread_v[k]);
            end
            checks++;
            if (maddr_v[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset[u%0d] MEM_ADDRESS: got %h expected 0", k, maddr_v[k]);
            end
            checks++;
            if (instr_v[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset[u%0d] INSTRUCTION: got %h expected 0", k, instr_v[k]);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_cold_start();
        rst = 1'b0;
        fetch(0, 32'd0, 1'b1, 32'd0, 7, "cold_start");
    endtask

    task automatic test_seq_hits();
        for (int i = 1; i < 4; i++) begin
            fetch(0, 32'(i * 4), 1'b0, 32'd0, 0, "seq_hit");
        end
    endtask

    task automatic test_block_boundary();
        fetch(0, 32'd16, 1'b1, 32'd1, 7, "boundary_miss");
        fetch(0, 32'd0,  1'b0, 32'd0, 0, "boundary_rehit");
    endtask

    task automatic test_conflict();
        do_reset();
        fetch(0, 32'd0,   1'b1, 32'd0, 7, "conflict_a");
        fetch(0, 32'd128, 1'b1, 32'd8, 7, "conflict_b");
        fetch(0, 32'd0,   1'b1, 32'd0, 7, "conflict_a_again");
    endtask

    task automatic test_reset_mid_fill();
        pc_v[0] = 32'd0;
        do_reset();
        @(posedge CLK);
        #1;
        checks++;
        if (mread_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL midfill_fetch_started MEM_READ: got %b expected 1", mread_v[0]);
        end
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mread_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL midfill_reset MEM_READ: got %b expected 0", mread_v[0]);
        end
        checks++;
        if (busy_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL midfill_reset BUSYWAIT: got %b expected 0", busy_v[0]);
        end
        @(posedge CLK);
        #1;
        rst = 1'b0;
        fetch(0, 32'd0, 1'b1, 32'd0, 7, "after_midfill_reset");
    endtask

    task automatic test_param_sweep();
        int   pcs1  [6] = '{0, 4, 8, 0, 4, 12};
        logic miss1 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   adr1  [6] = '{0, 1, 2, 0, 0, 3};
        int   pcs2  [8] = '{0, 4, 28, 32, 0, 512, 0, 36};
        logic miss2 [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   adr2  [8] = '{0, 0, 0, 1, 0, 16, 0, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fetch(1, 32'(pcs1[i]), miss1[i], 32'(adr1[i]), miss1[i] ? 3 : 0, "sweep_l2_b1");
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fetch(2, 32'(pcs2[i]), miss2[i], 32'(adr2[i]), miss2[i] ? 3 : 0, "sweep_l16_b8");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        for (int k = 0; k < 3; k++) pc_v[k] = 32'd0;
        #2;
        test_reset();
        test_cold_start();
        test_seq_hits();
        test_block_boundary();
        test_conflict();
        test_reset_mid_fill();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
